// File: rtl/pio_reg_target.sv
// pio_reg_target: host PIO target for the user register bank.
// Turns PIO DWORD writes/reads into per-register strobes (reg_td/reg_tv)
// and readback (reg_rd/reg_rv). Writes are byte-enable read-modify-write
// merges against the live readback. Writes to read-only or unmapped
// registers are dropped and counted. A read completion is held until the
// completion engine takes it.
module pio_reg_target #(
  parameter int          NREG   = 25,
  parameter int          AW     = 7,
  parameter logic [31:0] BAD_RD = 32'hDEADBEEF
) (
  input  logic                 user_clk,
  input  logic                 sys_rst_n,
  input  logic                 pio_wr_req,
  input  logic [AW-1:0]        pio_wr_addr,
  input  logic [31:0]          pio_wr_data,
  input  logic [3:0]           pio_wr_be,
  output logic                 pio_wr_ack,
  input  logic                 pio_rd_req,
  input  logic [AW-1:0]        pio_rd_addr,
  output logic                 pio_rd_ack,
  output logic [31:0]          rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [32*NREG-1:0]   reg_td,
  output logic [NREG-1:0]      reg_tv,
  input  logic [32*NREG-1:0]   reg_rd,
  input  logic [NREG-1:0]      reg_rv,
  output logic [15:0]          wr_drop_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_MERGE = 2'd1;
  localparam logic [1:0] ST_RD_FETCH = 2'd2;
  localparam logic [1:0] ST_RD_RESP  = 2'd3;

  logic [1:0]      state;
  logic [AW-1:0]   addr_q;
  logic [31:0]     data_q;
  logic [3:0]      be_q;
  logic            accept_wr;
  logic            accept_rd;
  logic            hit;
  logic [31:0]     sel_rd;
  logic            sel_rv;
  logic [NREG-1:0] sel_onehot;
  logic [31:0]     merged;
  logic            wr_ok;
  logic            wr_drop;

  // Counter saturates rather than wrapping so a flood of bad writes stays visible.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Each byte-enable bit covers one data byte.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Writes win over reads when both are raised in the same IDLE cycle.
  assign accept_wr = (state == ST_IDLE) && pio_wr_req;
  assign accept_rd = (state == ST_IDLE) && !pio_wr_req && pio_rd_req;

  // Decode the latched address against every register using the full address width.
  always_comb begin
    hit        = 1'b0;
    sel_rd     = '0;
    sel_rv     = 1'b0;
    sel_onehot = '0;
    for (int n = 0; n < NREG; n++) begin
      if (int'(addr_q) == n) begin
        hit           = 1'b1;
        sel_rd        = reg_rd[32*n +: 32];
        sel_rv        = reg_rv[n];
        sel_onehot[n] = 1'b1;
      end
    end
  end

  assign merged  = (data_q & byte_mask(be_q)) | (sel_rd & ~byte_mask(be_q));
  assign wr_ok   = hit && sel_rv && (be_q != 4'd0);
  assign wr_drop = (be_q != 4'd0) && !(hit && sel_rv);

  // Capture the accepted request; pure datapath, so it carries no reset.
  always_ff @(posedge user_clk) begin
    if (accept_wr) begin
      addr_q <= pio_wr_addr;
      data_q <= pio_wr_data;
      be_q   <= pio_wr_be;
    end else if (accept_rd) begin
      addr_q <= pio_rd_addr;
    end
  end

  // Transaction FSM: acks, write strobe, drop counting and read completion.
  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      pio_wr_ack  <= 1'b0;
      pio_rd_ack  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      reg_tv      <= '0;
      wr_drop_cnt <= '0;
    end else begin
      pio_wr_ack <= 1'b0;
      pio_rd_ack <= 1'b0;
      reg_tv     <= '0;
      case (state)
        ST_IDLE: begin
          if (accept_wr) begin
            pio_wr_ack <= 1'b1;
            state      <= ST_WR_MERGE;
          end else if (accept_rd) begin
            pio_rd_ack <= 1'b1;
            state      <= ST_RD_FETCH;
          end
        end
        ST_WR_MERGE: begin
          if (wr_ok)   reg_tv      <= sel_onehot;
          if (wr_drop) wr_drop_cnt <= sat_inc16(wr_drop_cnt);
          state <= ST_IDLE;
        end
        ST_RD_FETCH: begin
          rd_data  <= hit ? sel_rd : BAD_RD;
          rd_valid <= 1'b1;
          state    <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only the addressed register's slice is updated; the others keep their last value.
  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      reg_td <= '0;
    end else if (state == ST_WR_MERGE && wr_ok) begin
      for (int n = 0; n < NREG; n++) begin
        if (sel_onehot[n]) reg_td[32*n +: 32] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_pio_reg_target.sv
// tb_pio_reg_target: directed and random checks of pio_reg_target against
// a register-array model of the bank (last written value per register,
// byte-wise merge, saturating drop count).
module tb_pio_reg_target;

  localparam int NREG = 25;
  localparam int AW   = 7;

  logic                user_clk;
  logic                sys_rst_n;
  logic                pio_wr_req;
  logic [AW-1:0]       pio_wr_addr;
  logic [31:0]         pio_wr_data;
  logic [3:0]          pio_wr_be;
  logic                pio_wr_ack;
  logic                pio_rd_req;
  logic [AW-1:0]       pio_rd_addr;
  logic                pio_rd_ack;
  logic [31:0]         rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [32*NREG-1:0]  reg_td;
  logic [NREG-1:0]     reg_tv;
  logic [32*NREG-1:0]  reg_rd;
  logic [NREG-1:0]     reg_rv;
  logic [15:0]         wr_drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_td [NREG];
  int model_drop;

  pio_reg_target #(.NREG(NREG), .AW(AW), .BAD_RD(32'hDEADBEEF)) dut (
    .user_clk    (user_clk),
    .sys_rst_n   (sys_rst_n),
    .pio_wr_req  (pio_wr_req),
    .pio_wr_addr (pio_wr_addr),
    .pio_wr_data (pio_wr_data),
    .pio_wr_be   (pio_wr_be),
    .pio_wr_ack  (pio_wr_ack),
    .pio_rd_req  (pio_rd_req),
    .pio_rd_addr (pio_rd_addr),
    .pio_rd_ack  (pio_rd_ack),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .reg_td      (reg_td),
    .reg_tv      (reg_tv),
    .reg_rd      (reg_rd),
    .reg_rv      (reg_rv),
    .wr_drop_cnt (wr_drop_cnt)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] rd_slice(input int i);
    return reg_rd[32*i +: 32];
  endfunction

  function automatic logic [32*NREG-1:0] exp_td_vec();
    logic [32*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = model_td[i];
    return v;
  endfunction

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    logic [NREG-1:0] exp_tv;
    logic [31:0] cur;
    logic [31:0] nv;
    pio_wr_req  = 1'b1;
    pio_wr_addr = AW'(addr);
    pio_wr_data = data;
    pio_wr_be   = be;
    @(posedge user_clk); #1;
    total++;
    if (pio_wr_ack !== 1'b1) begin
      bad++; $display("FAIL wr_ack addr=%0d got=%b want=1", addr, pio_wr_ack);
    end
    total++;
    if (reg_tv !== '0) begin
      bad++; $display("FAIL early_tv addr=%0d got=%h want=0", addr, reg_tv);
    end
    pio_wr_req = 1'b0;
    exp_tv = '0;
    if (be != 4'd0) begin
      if (addr < NREG && reg_rv[addr] === 1'b1) begin
        cur = rd_slice(addr);
        for (int b = 0; b < 4; b++) nv[8*b +: 8] = be[b] ? data[8*b +: 8] : cur[8*b +: 8];
        model_td[addr] = nv;
        exp_tv[addr]   = 1'b1;
      end else if (model_drop < 65535) begin
        model_drop++;
      end
    end
    @(posedge user_clk); #1;
    total++;
    if (reg_tv !== exp_tv) begin
      bad++; $display("FAIL wr_tv addr=%0d got=%h want=%h", addr, reg_tv, exp_tv);
    end
    total++;
    if (reg_td !== exp_td_vec()) begin
      bad++; $display("FAIL wr_td addr=%0d got=%h want=%h", addr, reg_td, exp_td_vec());
    end
    total++;
    if (wr_drop_cnt !== 16'(model_drop)) begin
      bad++; $display("FAIL wr_drop addr=%0d got=%0d want=%0d", addr, wr_drop_cnt, model_drop);
    end
    total++;
    if (pio_wr_ack !== 1'b0) begin
      bad++; $display("FAIL wr_ack_pulse addr=%0d got=%b want=0", addr, pio_wr_ack);
    end
  endtask

  task automatic do_read(input int addr, input int stall);
    logic [31:0] exp;
    pio_rd_req  = 1'b1;
    pio_rd_addr = AW'(addr);
    rd_ready    = 1'b0;
    @(posedge user_clk); #1;
    total++;
    if (pio_rd_ack !== 1'b1) begin
      bad++; $display("FAIL rd_ack addr=%0d got=%b want=1", addr, pio_rd_ack);
    end
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_valid_early addr=%0d got=%b want=0", addr, rd_valid);
    end
    pio_rd_req = 1'b0;
    exp = (addr < NREG) ? rd_slice(addr) : 32'hDEADBEEF;
    @(posedge user_clk); #1;
    total++;
    if ({rd_valid, rd_data} !== {1'b1, exp}) begin
      bad++; $display("FAIL rd_resp addr=%0d got=%b/%h want=1/%h", addr, rd_valid, rd_data, exp);
    end
    rd_ready = (stall == 0);
    for (int i = 1; i <= stall; i++) begin
      if (addr < NREG) reg_rd[32*addr +: 32] = $urandom;
      @(posedge user_clk); #1;
      total++;
      if ({rd_valid, rd_data} !== {1'b1, exp}) begin
        bad++; $display("FAIL rd_hold addr=%0d cyc=%0d got=%b/%h want=1/%h", addr, i, rd_valid, rd_data, exp);
      end
      if (i == stall) rd_ready = 1'b1;
    end
    @(posedge user_clk); #1;
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_release addr=%0d got=%b want=0", addr, rd_valid);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n   = 1'b0;
    pio_wr_req  = 1'b0;
    pio_wr_addr = '0;
    pio_wr_data = '0;
    pio_wr_be   = '0;
    pio_rd_req  = 1'b0;
    pio_rd_addr = '0;
    rd_ready    = 1'b0;
    reg_rd      = '0;
    reg_rv      = '1;
    for (int i = 0; i < NREG; i++) model_td[i] = '0;
    model_drop = 0;
    repeat (3) @(posedge user_clk);
    #1;
    total++;
    if ({pio_wr_ack, pio_rd_ack, rd_valid, reg_tv} !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%b/%b/%b/%h want=0", pio_wr_ack, pio_rd_ack, rd_valid, reg_tv);
    end
    total++;
    if (rd_data !== 32'd0) begin
      bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data);
    end
    total++;
    if ({reg_td, wr_drop_cnt} !== '0) begin
      bad++; $display("FAIL reset_td_cnt got=%0d td_nonzero=%b want=0", wr_drop_cnt, |reg_td);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    total++;
    if ({pio_wr_ack, pio_rd_ack, rd_valid, reg_tv} !== '0) begin
      bad++; $display("FAIL idle_after_reset got=%b/%b/%b/%h want=0", pio_wr_ack, pio_rd_ack, rd_valid, reg_tv);
    end
  endtask

  task automatic test_write_basic();
    do_write(0, 32'h0000_0003, 4'hF);
    total++;
    if (reg_td[31:0] !== 32'h0000_0003) begin
      bad++; $display("FAIL basic_td0 got=%h want=00000003", reg_td[31:0]);
    end
  endtask

  task automatic test_byte_merge();
    reg_rd[32*20 +: 32] = 32'h1122_3344;
    do_write(20, 32'hAABB_CCDD, 4'b0010);
    total++;
    if (reg_td[32*20 +: 32] !== 32'h1122_CC44) begin
      bad++; $display("FAIL merge_td20 got=%h want=1122cc44", reg_td[32*20 +: 32]);
    end
    reg_rd[32*6 +: 32] = 32'h5566_7788;
    do_write(6, 32'hA1B2_C3D4, 4'b1001);
    do_write(5, 32'hFFFF_FFFF, 4'b0000);
  endtask

  task automatic test_write_protect();
    reg_rv[1] = 1'b0;
    do_write(1, 32'h1234_5678, 4'hF);
    do_write(30, 32'h8765_4321, 4'hF);
    do_write(40, 32'h0BAD_0BAD, 4'h0);
    total++;
    if (wr_drop_cnt !== 16'd2) begin
      bad++; $display("FAIL protect_cnt got=%0d want=2", wr_drop_cnt);
    end
    reg_rv[1] = 1'b1;
  endtask

  task automatic test_read_backpressure();
    reg_rd[32*9 +: 32] = 32'h0000_1000;
    do_read(9, 5);
    reg_rv[2] = 1'b0;
    reg_rd[32*2 +: 32] = 32'hCAFE_F00D;
    do_read(2, 0);
    reg_rv[2] = 1'b1;
    do_read(NREG, 1);
  endtask

  task automatic test_back_to_back();
    pio_rd_req  = 1'b1;
    pio_rd_addr = AW'(40);
    do_write(7, 32'h7777_0007, 4'hF);
    total++;
    if (pio_rd_ack !== 1'b0) begin
      bad++; $display("FAIL b2b_rd_early got=%b want=0", pio_rd_ack);
    end
    do_read(40, 2);
  endtask

  task automatic test_random();
    int addr;
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NREG; i++) reg_rd[32*i +: 32] = $urandom;
      reg_rv = NREG'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                         : int'($urandom_range(0, NREG-1));
      if ($urandom_range(0, 1) == 0)
        do_write(addr, $urandom, 4'($urandom));
      else
        do_read(addr, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    reg_rv = '1;
    do_write(3, 32'h0303_0303, 4'hF);
    reg_rd[32*9 +: 32] = 32'h0000_1000;
    pio_rd_req  = 1'b1;
    pio_rd_addr = AW'(9);
    rd_ready    = 1'b0;
    @(posedge user_clk); #1;
    pio_rd_req = 1'b0;
    @(posedge user_clk); #1;
    total++;
    if (rd_valid !== 1'b1) begin
      bad++; $display("FAIL mid_resp got=%b want=1", rd_valid);
    end
    sys_rst_n = 1'b0;
    #2;
    total++;
    if ({rd_valid, reg_tv, pio_wr_ack, pio_rd_ack} !== '0) begin
      bad++; $display("FAIL mid_reset_ctrl got=%b/%h want=0", rd_valid, reg_tv);
    end
    total++;
    if ({reg_td, wr_drop_cnt, rd_data} !== '0) begin
      bad++; $display("FAIL mid_reset_data cnt=%0d rd_data=%h td_nonzero=%b want=0", wr_drop_cnt, rd_data, |reg_td);
    end
    for (int i = 0; i < NREG; i++) model_td[i] = '0;
    model_drop = 0;
    @(posedge user_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge user_clk); #1;
    do_write(4, 32'h4444_0004, 4'hF);
    do_read(4, 0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_byte_merge();
    test_write_protect();
    test_read_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
